// File: rtl/fsm_rr_arbiter_if.sv
// Arbiter request/grant bundle.
// The master side (requesters) drives req/done. The slave side (the arbiter)
// drives gnt, gnt_id, busy and state.
interface fsm_rr_arbiter_if;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [1:0] state;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_id,
        input  busy,
        input  state
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_id,
        output busy,
        output state
    );
endinterface

// File: rtl/fsm_rr_arbiter.sv
// Four-requester round-robin arbiter built as a Moore FSM
// (IDLE -> GRANT -> HOLD -> RELEASE).
// Optional feature: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// granted cycles. When it is undefined, a grant lasts until done is pulsed or
// req[owner] drops.
// All outputs come straight from registers. gnt and busy are precomputed from
// the next state and owner, so they always match state and gnt_id.
module fsm_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fsm_rr_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Reject hold limits the 8-bit counter cannot represent
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("fsm_rr_arbiter: MAX_HOLD must be within 2..255");
    end

    // First asserted request scanning start, start+1, ... modulo 4
    function automatic logic [1:0] f_rr_pick(input logic [3:0] req_v, input logic [1:0] start);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && req_v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    // One-hot decode of a requester index
    function automatic logic [3:0] f_onehot(input logic [1:0] id);
        return 4'b0001 << id;
    endfunction

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] w_ptr_nxt;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       w_timeout;
    logic       w_owner_req;
    logic [1:0] w_win_idle;
    logic [1:0] w_win_rel;

    assign w_owner_req = bus.req[r_owner];
    assign w_win_idle  = f_rr_pick(bus.req, r_ptr);
    assign w_win_rel   = f_rr_pick(bus.req, r_owner + 2'd1);

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    // Timeout fires on the last permitted HOLD cycle
    always_comb begin
        w_timeout = 1'b0;
        if ((r_state == ST_HOLD) && (r_cnt == HOLD_LAST)) begin
            w_timeout = 1'b1;
        end else begin
            w_timeout = 1'b0;
        end
    end

    // Hold counter: cleared on a new grant, saturating increment while granted
    always_comb begin
        w_cnt_nxt = r_cnt;
        case (r_state)
            ST_IDLE:    w_cnt_nxt = 8'd0;
            ST_GRANT,
            ST_HOLD:    w_cnt_nxt = (r_cnt == 8'd255) ? r_cnt : (r_cnt + 8'd1);
            ST_RELEASE: w_cnt_nxt = 8'd0;
            default:    w_cnt_nxt = 8'd0;
        endcase
    end

    // Hold counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    // Without the timeout option a grant is never cut short
    always_comb begin
        w_timeout = 1'b0;
    end
`endif

    // Next-state, owner and search-pointer logic
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_win_idle;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (bus.done || !w_owner_req) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.done || !w_owner_req || w_timeout) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_RELEASE: begin
                w_ptr_nxt = r_owner + 2'd1;
                if (|bus.req) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_win_rel;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant vector for the upcoming state so the gnt register tracks state/owner
    always_comb begin
        w_gnt_nxt = 4'd0;
        if ((w_state_nxt == ST_GRANT) || (w_state_nxt == ST_HOLD)) begin
            w_gnt_nxt = f_onehot(w_owner_nxt);
        end else begin
            w_gnt_nxt = 4'd0;
        end
        w_busy_nxt = |w_gnt_nxt;
    end

    // State, owner, pointer and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            r_gnt   <= 4'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    assign bus.gnt    = r_gnt;
    assign bus.gnt_id = r_owner;
    assign bus.busy   = r_busy;
    assign bus.state  = r_state;

endmodule
